// File: rtl/membus_arb_if.sv
// Two-master memory-bus arbiter signal bundle: master request/response side plus the shared membus side.
// The arbiter connects through the slave modport; the masters/bus environment through the master modport.
interface membus_arb_if #(
  parameter int width      = 16,
  parameter int addr_width = 9
);
  logic                  m0_req;
  logic                  m1_req;
  logic                  m0_we;
  logic                  m1_we;
  logic [addr_width-1:0] m0_addr;
  logic [addr_width-1:0] m1_addr;
  logic [width-1:0]      m0_wdata;
  logic [width-1:0]      m1_wdata;
  logic                  m0_ack;
  logic                  m1_ack;
  logic                  m0_rvalid;
  logic                  m1_rvalid;
  logic [width-1:0]      m0_rdata;
  logic [width-1:0]      m1_rdata;
  logic [addr_width-1:0] bus_addr;
  logic [width-1:0]      bus_data_write;
  logic                  bus_w_strobe;
  logic [width-1:0]      bus_data_read;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  bus_data_read,
    output m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output bus_addr, bus_data_write, bus_w_strobe
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output bus_data_read,
    input  m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  bus_addr, bus_data_write, bus_w_strobe
  );
endinterface

// File: rtl/membus_arb.sv
// Round-robin arbiter giving two masters zero-wait access to a single membus,
// returning read data one cycle after the accepted address.
module membus_arb #(
  parameter int width      = 16,
  parameter int addr_width = 9
) (
  input  logic          clk,
  input  logic          reset,
  membus_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } owner_t;

  logic                  last_grant;
  owner_t                rd_owner;
  logic                  grant0;
  logic                  grant1;
  logic [addr_width-1:0] sel_addr;
  logic [width-1:0]      sel_wdata;
  logic                  sel_we;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (bus.m0_req && bus.m1_req) begin
        // Contention goes to whoever did not win last time.
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.m0_req;
        grant1 = bus.m1_req;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (grant0) begin
      sel_addr  = bus.m0_addr;
      sel_wdata = bus.m0_wdata;
      sel_we    = bus.m0_we;
    end else if (grant1) begin
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
      sel_we    = bus.m1_we;
    end
  end

  assign bus.m0_ack         = grant0;
  assign bus.m1_ack         = grant1;
  assign bus.bus_addr       = sel_addr;
  assign bus.bus_data_write = sel_wdata;
  assign bus.bus_w_strobe   = sel_we;

  // The reset gate drops a return whose read was accepted just before reset rose.
  assign bus.m0_rvalid = (rd_owner == OWN_M0) && !reset;
  assign bus.m1_rvalid = (rd_owner == OWN_M1) && !reset;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.bus_data_read : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.bus_data_read : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: reset forces last_grant to 1 so m0 wins the first contention, and drops any pending read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_owner   <= OWN_NONE;
    end else begin
      rd_owner <= OWN_NONE;
      if (grant0) begin
        last_grant <= 1'b0;
        if (!bus.m0_we) rd_owner <= OWN_M0;
      end else if (grant1) begin
        last_grant <= 1'b1;
        if (!bus.m1_we) rd_owner <= OWN_M1;
      end
    end
  end

endmodule

// File: tb/tb_membus_arb.sv
// Bench for membus_arb: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of arbitration and read returns.
module tb_membus_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  membus_arb_if #(.width(16), .addr_width(9)) bus ();

  membus_arb #(.width(16), .addr_width(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Membus model: registered read one cycle after the address, write on strobe.
  logic [15:0] env_mem [512];
  always @(posedge clk) begin
    if (bus.bus_w_strobe) env_mem[bus.bus_addr] <= bus.bus_data_write;
    bus.bus_data_read <= env_mem[bus.bus_addr];
  end

  // Transaction-level reference: who wins, what goes on the bus, which read returns next.
  logic [15:0] model_mem [512];
  int          m_last = 1;
  int          pend   = -1;
  logic [15:0] pend_data = '0;
  logic        e_ack0 = 1'b0;
  logic        e_ack1 = 1'b0;
  int          wait0 = 0;
  int          wait1 = 0;
  int          winner;
  logic [8:0]  ea;
  logic [15:0] ed;
  logic        ew;
  logic        ev0;
  logic        ev1;

  always @(negedge clk) begin
    #2;
    winner = -1;
    if (!reset) begin
      if (bus.m0_req && bus.m1_req) winner = (m_last == 0) ? 1 : 0;
      else if (bus.m0_req)          winner = 0;
      else if (bus.m1_req)          winner = 1;
    end
    ea = (winner == 0) ? bus.m0_addr  : (winner == 1) ? bus.m1_addr  : 9'h000;
    ed = (winner == 0) ? bus.m0_wdata : (winner == 1) ? bus.m1_wdata : 16'h0000;
    ew = (winner == 0) ? bus.m0_we    : (winner == 1) ? bus.m1_we    : 1'b0;
    ev0 = !reset && (pend == 0);
    ev1 = !reset && (pend == 1);

    check("m0_ack",         32'(bus.m0_ack),         32'(winner == 0));
    check("m1_ack",         32'(bus.m1_ack),         32'(winner == 1));
    check("bus_addr",       32'(bus.bus_addr),       32'(ea));
    check("bus_data_write", 32'(bus.bus_data_write), 32'(ed));
    check("bus_w_strobe",   32'(bus.bus_w_strobe),   32'(ew));
    check("m0_rvalid",      32'(bus.m0_rvalid),      32'(ev0));
    check("m1_rvalid",      32'(bus.m1_rvalid),      32'(ev1));
    check("m0_rdata",       32'(bus.m0_rdata),       ev0 ? 32'(pend_data) : 32'h0);
    check("m1_rdata",       32'(bus.m1_rdata),       ev1 ? 32'(pend_data) : 32'h0);

    // Under contention nobody may wait two cycles in a row.
    wait0 = (!reset && bus.m0_req && !bus.m0_ack) ? wait0 + 1 : 0;
    wait1 = (!reset && bus.m1_req && !bus.m1_ack) ? wait1 + 1 : 0;
    check("starve_m0", 32'(wait0 > 1), 32'h0);
    check("starve_m1", 32'(wait1 > 1), 32'h0);

    if (reset) begin
      m_last = 1;
      pend   = -1;
    end else begin
      pend = -1;
      if (winner >= 0) begin
        m_last = winner;
        if (ew) model_mem[ea] = ed;
        else begin
          pend      = winner;
          pend_data = model_mem[ea];
        end
      end
    end
    e_ack0 = (winner == 0);
    e_ack1 = (winner == 1);
  end

  task automatic cyc(input logic rs,
                     input logic r0, input logic w0, input logic [8:0] a0, input logic [15:0] d0,
                     input logic r1, input logic w1, input logic [8:0] a1, input logic [15:0] d1);
    @(negedge clk);
    reset        = rs;
    bus.m0_req   = r0;
    bus.m0_we    = w0;
    bus.m0_addr  = a0;
    bus.m0_wdata = d0;
    bus.m1_req   = r1;
    bus.m1_we    = w1;
    bus.m1_addr  = a1;
    bus.m1_wdata = d1;
    #3;
  endtask

  task automatic idle(input logic rs);
    cyc(rs, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
  endtask

  function automatic logic [8:0] rand_addr();
    logic [8:0] a;
    if ($urandom_range(0, 9) == 0) a = 9'h100 | 9'($urandom_range(0, 1));
    else                            a = 9'($urandom_range(0, 255));
    return a;
  endfunction

  initial begin
    int i0;
    int i1;
    logic p0, p1, w0, w1, rs;
    logic [8:0]  a0, a1;
    logic [15:0] d0, d1;

    for (int i = 0; i < 512; i++) begin
      env_mem[i]   = 16'(i * 16'h0101) ^ 16'h5A5A;
      model_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    env_mem[5]   = 16'h1234;
    model_mem[5] = 16'h1234;
    reset = 1'b1;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

    // Reset holds everything quiet even with requests present.
    idle(1'b1);
    cyc(1'b1, 1'b1, 1'b0, 9'h005, 16'h0000, 1'b1, 1'b1, 9'h007, 16'hAAAA);
    check("rst_m0_ack", 32'(bus.m0_ack), 32'h0);
    check("rst_m1_ack", 32'(bus.m1_ack), 32'h0);
    check("rst_strobe", 32'(bus.bus_w_strobe), 32'h0);
    check("rst_addr",   32'(bus.bus_addr), 32'h0);

    // Single read from m0.
    cyc(1'b0, 1'b1, 1'b0, 9'h005, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
    check("rd_m0_ack",  32'(bus.m0_ack), 32'h1);
    check("rd_m1_ack",  32'(bus.m1_ack), 32'h0);
    check("rd_addr",    32'(bus.bus_addr), 32'h005);
    idle(1'b0);
    check("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    check("rd_m0_rdata",  32'(bus.m0_rdata), 32'h1234);
    check("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    check("rd_m1_rdata",  32'(bus.m1_rdata), 32'h0);

    // Contention right after reset: m0 first, then m1's write.
    idle(1'b1);
    cyc(1'b0, 1'b1, 1'b0, 9'h010, 16'h0000, 1'b1, 1'b1, 9'h011, 16'hBEEF);
    check("cont_m0_ack", 32'(bus.m0_ack), 32'h1);
    check("cont_m1_ack", 32'(bus.m1_ack), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b1, 9'h011, 16'hBEEF);
    check("cont_m1_ack2",  32'(bus.m1_ack), 32'h1);
    check("cont_strobe",   32'(bus.bus_w_strobe), 32'h1);
    check("cont_addr",     32'(bus.bus_addr), 32'h011);
    check("cont_wdata",    32'(bus.bus_data_write), 32'hBEEF);
    check("cont_m0_rval",  32'(bus.m0_rvalid), 32'h1);
    idle(1'b0);
    check("cont_m1_norv", 32'(bus.m1_rvalid), 32'h0);

    // Four reads each, both masters requesting continuously.
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'(i0 < 4), 1'b0, 9'(9'h020 + i0), 16'h0000,
                1'(i1 < 4), 1'b0, 9'(9'h030 + i1), 16'h0000);
      check("bb_m0_ack", 32'(bus.m0_ack), 32'(k % 2 == 0));
      check("bb_m1_ack", 32'(bus.m1_ack), 32'(k % 2 == 1));
      if (k > 0) check("bb_prev_rvalid",
                       32'((k % 2 == 1) ? bus.m0_rvalid : bus.m1_rvalid), 32'h1);
      if (k % 2 == 0) i0++;
      else            i1++;
    end
    idle(1'b0);
    check("bb_last_rvalid", 32'(bus.m1_rvalid), 32'h1);
    check("bb_last_rdata",  32'(bus.m1_rdata), 32'((9'h033 * 16'h0101) ^ 16'h5A5A));

    // GPIO write from m1.
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b1, 9'h100, 16'h0003);
    check("gpio_strobe", 32'(bus.bus_w_strobe), 32'h1);
    check("gpio_addr",   32'(bus.bus_addr), 32'h100);
    idle(1'b0);
    check("gpio_strobe_off", 32'(bus.bus_w_strobe), 32'h0);
    check("gpio_no_rvalid",  32'(bus.m1_rvalid), 32'h0);

    // Reset in the return cycle of an m1 read; m0 wins afterwards.
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h040, 16'h0000);
    check("rr_m1_ack", 32'(bus.m1_ack), 32'h1);
    idle(1'b1);
    check("rr_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 9'h041, 16'h0000, 1'b1, 1'b0, 9'h042, 16'h0000);
    check("rr_m0_first", 32'(bus.m0_ack), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h042, 16'h0000);
    check("rr_m1_next", 32'(bus.m1_ack), 32'h1);

    // Same, but m0 was the last winner: reset must still hand m0 the first contention.
    cyc(1'b0, 1'b1, 1'b0, 9'h050, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
    idle(1'b1);
    check("rr0_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 9'h051, 16'h0000, 1'b1, 1'b0, 9'h052, 16'h0000);
    check("rr0_m0_first", 32'(bus.m0_ack), 32'h1);
    check("rr0_m1_wait",  32'(bus.m1_ack), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h052, 16'h0000);

    // Idle cycles keep the bus at zero and keep the round-robin pointer.
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      check("idle_addr",   32'(bus.bus_addr), 32'h0);
      check("idle_strobe", 32'(bus.bus_w_strobe), 32'h0);
    end
    cyc(1'b0, 1'b1, 1'b0, 9'h060, 16'h0000, 1'b1, 1'b0, 9'h061, 16'h0000);
    check("idle_keep_m0", 32'(bus.m0_ack), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h061, 16'h0000);
    check("idle_keep_m1", 32'(bus.m1_ack), 32'h1);
    idle(1'b0);

    // Randomized traffic: each master holds its access until accepted.
    p0 = 1'b0; p1 = 1'b0;
    w0 = 1'b0; w1 = 1'b0;
    a0 = '0;   a1 = '0;
    d0 = '0;   d1 = '0;
    for (int n = 0; n < 600; n++) begin
      if (e_ack0) p0 = 1'b0;
      if (e_ack1) p1 = 1'b0;
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; w0 = 1'($urandom_range(0, 1)); a0 = rand_addr(); d0 = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1; w1 = 1'($urandom_range(0, 1)); a1 = rand_addr(); d1 = 16'($urandom);
      end
      rs = ($urandom_range(0, 60) == 0);
      cyc(rs, p0, w0, a0, d0, p1, w1, a1, d1);
    end
    idle(1'b0);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
